datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 31 +++
 rtl/datapath_if.sv | 35 +++
 rtl/datapath_alu.sv | 39 +++
 rtl/datapath.sv | 120 ++++++++++++
 tb/tb_datapath.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared widths, IR field positions and ALU op encoding for the datapath.
// Imported by the interface, the ALU and the top-level datapath.
package datapath_pkg;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int IDX_W    = 4;
   localparam int RA_LSB   = 23;
   localparam int RB_LSB   = 19;
   localparam int RC_LSB   = 15;
   localparam int C_MSB    = 18;

   typedef enum logic [3:0] {
      OP_NONE,
      OP_INC,
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_SHR,
      OP_SHL,
      OP_ROR,
      OP_ROL,
      OP_NEG,
      OP_NOT
   } alu_op_e;

   // The immediate field of IR widened to a full data word.
   function automatic logic [DATA_W-1:0] sign_ext_c(input logic [C_MSB:0] c);
      return {{(DATA_W-1-C_MSB){c[C_MSB]}}, c};
   endfunction
endpackage

// File: rtl/datapath_if.sv
// Control strobes, memory data and observable register state of the datapath.
// The controller (master) drives the strobes; the datapath (slave) drives the state.
interface datapath_if;
   import datapath_pkg::*;

   logic [DATA_W-1:0]   Mdatain;
   logic                read;
   logic                PCout, Zlowout, MDRout, Cout, Rout, BAout;
   logic                Gra, Grb, Grc;
   logic                Rin, MARin, Zin, PCin, MDRin, IRin, Yin;
   logic                IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;

   logic [DATA_W-1:0]   R0, R1, R2, R3, R4, R5, R6, R7;
   logic [DATA_W-1:0]   R8, R9, R10, R11, R12, R13, R14, R15;
   logic [DATA_W-1:0]   Hi, Lo, PC, MAR, MDR, IR;
   logic [DATA_W-1:0]   bus_mux_out, C_sign_ext;
   logic [2*DATA_W-1:0] ALUout, Z;
   logic [NUM_REGS-1:0] Rins, Routs;

   modport master (
      output Mdatain, read, PCout, Zlowout, MDRout, Cout, Rout, BAout,
             Gra, Grb, Grc, Rin, MARin, Zin, PCin, MDRin, IRin, Yin,
             IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
      input  R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15,
             Hi, Lo, PC, MAR, MDR, IR, bus_mux_out, C_sign_ext, ALUout, Z, Rins, Routs
   );

   modport slave (
      input  Mdatain, read, PCout, Zlowout, MDRout, Cout, Rout, BAout,
             Gra, Grb, Grc, Rin, MARin, Zin, PCin, MDRin, IRin, Yin,
             IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
      output R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15,
             Hi, Lo, PC, MAR, MDR, IR, bus_mux_out, C_sign_ext, ALUout, Z, Rins, Routs
   );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; upper result half is always zero.
module datapath_alu
   import datapath_pkg::*;
(
   input  alu_op_e             i_op,
   input  logic [DATA_W-1:0]   i_a,
   input  logic [DATA_W-1:0]   i_b,
   output logic [2*DATA_W-1:0] o_result
);
   logic [4:0]        w_sh;
   logic [DATA_W-1:0] w_ror;
   logic [DATA_W-1:0] w_rol;
   logic [DATA_W-1:0] w_res;

   assign w_sh = i_b[4:0];
   // A shift by 32 yields zero, so a zero rotate amount leaves A intact.
   assign w_ror = (i_a >> w_sh) | (i_a << (6'd32 - {1'b0, w_sh}));
   assign w_rol = (i_a << w_sh) | (i_a >> (6'd32 - {1'b0, w_sh}));

   always_comb begin
      w_res = '0;
      case (i_op)
         OP_INC:  w_res = i_b + 32'd1;
         OP_ADD:  w_res = i_a + i_b;
         OP_SUB:  w_res = i_a - i_b;
         OP_AND:  w_res = i_a & i_b;
         OP_OR:   w_res = i_a | i_b;
         OP_SHR:  w_res = i_a >> w_sh;
         OP_SHL:  w_res = i_a << w_sh;
         OP_ROR:  w_res = w_ror;
         OP_ROL:  w_res = w_rol;
         OP_NEG:  w_res = -i_b;
         OP_NOT:  w_res = ~i_b;
         default: w_res = '0;
      endcase
   end

   assign o_result = {{DATA_W{1'b0}}, w_res};
endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, IR field decode, bus mux and Y/Z around the ALU.
// DATAPATH_R0_BAOUT_EN: when defined, BAout with R0 selected puts zero on the bus.
module datapath
   import datapath_pkg::*;
(
   input logic        clk,
   input logic        clear,
   datapath_if.slave  dp
);
   logic [DATA_W-1:0]   r_gpr [NUM_REGS];
   logic [DATA_W-1:0]   r_y, r_pc, r_mar, r_mdr, r_ir;
   logic [2*DATA_W-1:0] r_z;

   logic [IDX_W-1:0]    w_idx;
   logic                w_any_gr;
   logic [NUM_REGS-1:0] w_dec, w_rins, w_routs;
   logic [DATA_W-1:0]   w_gpr_val, w_c_ext, w_bus;
   logic [2*DATA_W-1:0] w_alu_out;
   alu_op_e             w_op;

   assign w_idx = ({IDX_W{dp.Gra}} & r_ir[RA_LSB +: IDX_W])
                | ({IDX_W{dp.Grb}} & r_ir[RB_LSB +: IDX_W])
                | ({IDX_W{dp.Grc}} & r_ir[RC_LSB +: IDX_W]);
   assign w_any_gr = dp.Gra | dp.Grb | dp.Grc;
   assign w_dec    = w_any_gr ? (NUM_REGS'(1) << w_idx) : '0;
   assign w_rins   = w_dec & {NUM_REGS{dp.Rin}};
   assign w_routs  = w_dec & {NUM_REGS{dp.Rout | dp.BAout}};
   assign w_c_ext  = sign_ext_c(r_ir[C_MSB:0]);

`ifdef DATAPATH_R0_BAOUT_EN
   // Base addressing treats R0 as a constant zero rather than its contents.
   assign w_gpr_val = (dp.BAout && w_idx == '0) ? '0 : r_gpr[w_idx];
`else
   assign w_gpr_val = r_gpr[w_idx];
`endif

   always_comb begin
      w_bus = '0;
      if (|w_routs)        w_bus = w_gpr_val;
      else if (dp.PCout)   w_bus = r_pc;
      else if (dp.Zlowout) w_bus = r_z[DATA_W-1:0];
      else if (dp.MDRout)  w_bus = r_mdr;
      else if (dp.Cout)    w_bus = w_c_ext;
   end

   always_comb begin
      w_op = OP_NONE;
      if (dp.IncPC)    w_op = OP_INC;
      else if (dp.ADD) w_op = OP_ADD;
      else if (dp.SUB) w_op = OP_SUB;
      else if (dp.AND) w_op = OP_AND;
      else if (dp.OR)  w_op = OP_OR;
      else if (dp.SHR) w_op = OP_SHR;
      else if (dp.SHL) w_op = OP_SHL;
      else if (dp.ROR) w_op = OP_ROR;
      else if (dp.ROL) w_op = OP_ROL;
      else if (dp.NEG) w_op = OP_NEG;
      else if (dp.NOT) w_op = OP_NOT;
   end

   datapath_alu u_alu (
      .i_op     (w_op),
      .i_a      (r_y),
      .i_b      (w_bus),
      .o_result (w_alu_out)
   );

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < NUM_REGS; i++) r_gpr[i] <= '0;
         r_y   <= '0;
         r_z   <= '0;
         r_pc  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_ir  <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rins[i]) r_gpr[i] <= w_bus;
         end
         if (dp.Yin)   r_y   <= w_bus;
         if (dp.Zin)   r_z   <= w_alu_out;
         if (dp.PCin)  r_pc  <= w_bus;
         if (dp.MARin) r_mar <= w_bus;
         if (dp.IRin)  r_ir  <= w_bus;
         if (dp.MDRin) r_mdr <= dp.read ? dp.Mdatain : w_bus;
      end
   end

   assign dp.R0  = r_gpr[0];
   assign dp.R1  = r_gpr[1];
   assign dp.R2  = r_gpr[2];
   assign dp.R3  = r_gpr[3];
   assign dp.R4  = r_gpr[4];
   assign dp.R5  = r_gpr[5];
   assign dp.R6  = r_gpr[6];
   assign dp.R7  = r_gpr[7];
   assign dp.R8  = r_gpr[8];
   assign dp.R9  = r_gpr[9];
   assign dp.R10 = r_gpr[10];
   assign dp.R11 = r_gpr[11];
   assign dp.R12 = r_gpr[12];
   assign dp.R13 = r_gpr[13];
   assign dp.R14 = r_gpr[14];
   assign dp.R15 = r_gpr[15];

   // Hi/Lo exist for the multiply/divide extension but have no load path yet.
   assign dp.Hi          = '0;
   assign dp.Lo          = '0;
   assign dp.PC          = r_pc;
   assign dp.MAR         = r_mar;
   assign dp.MDR         = r_mdr;
   assign dp.IR          = r_ir;
   assign dp.Z           = r_z;
   assign dp.bus_mux_out = w_bus;
   assign dp.C_sign_ext  = w_c_ext;
   assign dp.ALUout      = w_alu_out;
   assign dp.Rins        = w_rins;
   assign dp.Routs       = w_routs;
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed sequences plus an ALU vector table with a Z scoreboard.
module tb_datapath;
   logic clk = 1'b0;
   logic clear;

   datapath_if dp_if ();

   datapath dut (
      .clk   (clk),
      .clear (clear),
      .dp    (dp_if)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb_q [$];

   localparam logic [10:0] M_INC = 11'h400, M_ADD = 11'h200, M_SUB = 11'h100;
   localparam logic [10:0] M_AND = 11'h080, M_OR  = 11'h040, M_SHR = 11'h020;
   localparam logic [10:0] M_SHL = 11'h010, M_ROR = 11'h008, M_ROL = 11'h004;
   localparam logic [10:0] M_NEG = 11'h002, M_NOT = 11'h001;

   typedef struct {
      logic [10:0] ops;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [10:0] m);
      dp_if.IncPC = m[10]; dp_if.ADD = m[9]; dp_if.SUB = m[8]; dp_if.AND = m[7];
      dp_if.OR    = m[6];  dp_if.SHR = m[5]; dp_if.SHL = m[4]; dp_if.ROR = m[3];
      dp_if.ROL   = m[2];  dp_if.NEG = m[1]; dp_if.NOT = m[0];
   endtask

   task automatic idle();
      dp_if.read = 0;
      dp_if.PCout = 0; dp_if.Zlowout = 0; dp_if.MDRout = 0; dp_if.Cout = 0;
      dp_if.Rout = 0; dp_if.BAout = 0;
      dp_if.Gra = 0; dp_if.Grb = 0; dp_if.Grc = 0;
      dp_if.Rin = 0; dp_if.MARin = 0; dp_if.Zin = 0; dp_if.PCin = 0;
      dp_if.MDRin = 0; dp_if.IRin = 0; dp_if.Yin = 0;
      set_ops(11'h0);
   endtask

   task automatic load_mdr(input logic [31:0] v);
      dp_if.Mdatain = v;
      dp_if.read    = 1;
      dp_if.MDRin   = 1;
      tick();
      dp_if.MDRin = 0;
      dp_if.read  = 0;
   endtask

   task automatic all_zero(input string name);
      logic [31:0] acc;
      acc = dp_if.R0 | dp_if.R1 | dp_if.R2 | dp_if.R3 | dp_if.R4 | dp_if.R5 | dp_if.R6
          | dp_if.R7 | dp_if.R8 | dp_if.R9 | dp_if.R10 | dp_if.R11 | dp_if.R12 | dp_if.R13
          | dp_if.R14 | dp_if.R15 | dp_if.Hi | dp_if.Lo | dp_if.PC | dp_if.MAR | dp_if.MDR
          | dp_if.IR | dp_if.Z[31:0] | dp_if.Z[63:32];
      chk(name, {32'h0, acc}, 64'h0);
   endtask

   initial begin
      logic [63:0] exp64;

      vecs[0]  = '{M_ADD,         32'h00000005, 32'h00000007, 32'h0000000C};
      vecs[1]  = '{M_SUB,         32'h00000005, 32'h00000007, 32'hFFFFFFFE};
      vecs[2]  = '{M_AND,         32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
      vecs[3]  = '{M_OR,          32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
      vecs[4]  = '{M_SHR,         32'h80000001, 32'h00000001, 32'h40000000};
      vecs[5]  = '{M_SHL,         32'h80000001, 32'h00000004, 32'h00000010};
      vecs[6]  = '{M_ROR,         32'h80000001, 32'h00000001, 32'hC0000000};
      vecs[7]  = '{M_ROL,         32'h80000001, 32'h00000004, 32'h00000018};
      vecs[8]  = '{M_NEG,         32'h12345678, 32'h00000001, 32'hFFFFFFFF};
      vecs[9]  = '{M_NOT,         32'h12345678, 32'h0000FFFF, 32'hFFFF0000};
      vecs[10] = '{M_INC,         32'h12345678, 32'hFFFFFFFF, 32'h00000000};
      vecs[11] = '{M_SHR,         32'h80000000, 32'h00000021, 32'h40000000};
      vecs[12] = '{M_ADD | M_SUB, 32'h00000005, 32'h00000007, 32'h0000000C};
      vecs[13] = '{11'h000,       32'h12345678, 32'h00000003, 32'h00000000};

      idle();
      dp_if.Mdatain = '0;
      clear = 1;
      #3;
      all_zero("reset_regs");
      chk("reset_bus", {32'h0, dp_if.bus_mux_out}, 64'h0);
      clear = 0;
      tick();

      // MDR from memory, then onto the bus into PC
      load_mdr(32'h0);
      dp_if.MDRout = 1; dp_if.PCin = 1;
      tick(); idle();
      chk("mdr_zero", {32'h0, dp_if.MDR}, 64'h0);
      chk("pc_zero", {32'h0, dp_if.PC}, 64'h0);

      // Instruction fetch: MAR<=PC, Z<=PC+1, PC<=Z
      dp_if.PCout = 1; dp_if.MARin = 1; dp_if.IncPC = 1; dp_if.Zin = 1;
      tick(); idle();
      chk("fetch_mar", {32'h0, dp_if.MAR}, 64'h0);
      chk("fetch_z", dp_if.Z, 64'h1);
      dp_if.Zlowout = 1; dp_if.PCin = 1;
      tick(); idle();
      chk("fetch_pc", {32'h0, dp_if.PC}, 64'h1);

      // Z drives the bus while being reloaded: captures old Z + 1
      dp_if.Zlowout = 1; dp_if.IncPC = 1; dp_if.Zin = 1;
      #1;
      chk("z_loop_bus", {32'h0, dp_if.bus_mux_out}, 64'h1);
      tick(); idle();
      chk("z_loop_z", dp_if.Z, 64'h2);

      load_mdr(32'h00800085);
      dp_if.MDRout = 1; dp_if.IRin = 1;
      tick(); idle();
      chk("ir_load", {32'h0, dp_if.IR}, 64'h00800085);
      chk("c_ext_pos", {32'h0, dp_if.C_sign_ext}, 64'h85);

      // Rb field is R0: base address of zero into Y
      dp_if.Grb = 1; dp_if.BAout = 1; dp_if.Yin = 1;
      #1;
      chk("baout_bus", {32'h0, dp_if.bus_mux_out}, 64'h0);
      chk("baout_routs", {48'h0, dp_if.Routs}, 64'h1);
      tick(); idle();
      dp_if.Cout = 1; dp_if.ADD = 1; dp_if.Zin = 1;
      tick(); idle();
      chk("ea_z", dp_if.Z, 64'h85);
      dp_if.Zlowout = 1; dp_if.MARin = 1;
      tick(); idle();
      chk("ea_mar", {32'h0, dp_if.MAR}, 64'h85);

      dp_if.Rin = 1;
      #1;
      chk("rins_no_gr", {48'h0, dp_if.Rins}, 64'h0);
      idle();
      load_mdr(32'h2);
      dp_if.MDRout = 1; dp_if.Gra = 1; dp_if.Rin = 1;
      #1;
      chk("rins_r1", {48'h0, dp_if.Rins}, 64'h2);
      tick(); idle();
      chk("r1_load", {32'h0, dp_if.R1}, 64'h2);
      dp_if.Gra = 1; dp_if.Rout = 1;
      #1;
      chk("r1_bus", {32'h0, dp_if.bus_mux_out}, 64'h2);
      chk("routs_r1", {48'h0, dp_if.Routs}, 64'h2);
      idle();

      for (int i = 0; i < 14; i++) begin
         idle();
         load_mdr(vecs[i].a);
         dp_if.MDRout = 1; dp_if.Yin = 1;
         tick(); idle();
         load_mdr(vecs[i].b);
         dp_if.MDRout = 1; dp_if.Zin = 1;
         set_ops(vecs[i].ops);
         #1;
         chk($sformatf("alu_out[%0d]", i), dp_if.ALUout, {32'h0, vecs[i].exp});
         sb_q.push_back({32'h0, vecs[i].exp});
         tick(); idle();
         if (sb_q.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", i), 64'h1, 64'h0);
         end else begin
            exp64 = sb_q.pop_front();
            chk($sformatf("z_reg[%0d]", i), dp_if.Z, exp64);
         end
      end

      // Rotate/shift from R1 via Y, then clear lands between edges
      load_mdr(32'h80000001);
      dp_if.MDRout = 1; dp_if.Gra = 1; dp_if.Rin = 1;
      tick(); idle();
      chk("r1_rot_src", {32'h0, dp_if.R1}, 64'h80000001);
      dp_if.Gra = 1; dp_if.Rout = 1; dp_if.Yin = 1;
      tick(); idle();
      load_mdr(32'h1);
      dp_if.MDRout = 1; dp_if.ROR = 1;
      #1;
      chk("ror_r1", dp_if.ALUout, 64'hC0000000);
      dp_if.ROR = 0; dp_if.SHR = 1;
      #1;
      chk("shr_r1", dp_if.ALUout, 64'h40000000);
      dp_if.Zin = 1; dp_if.PCin = 1;
      clear = 1;
      #1;
      all_zero("clear_async");
      tick();
      all_zero("clear_holds");
      clear = 0;
      idle();
      load_mdr(32'h00001234);
      chk("resume_mdr", {32'h0, dp_if.MDR}, 64'h1234);

      load_mdr(32'h00040000);
      dp_if.MDRout = 1; dp_if.IRin = 1;
      tick(); idle();
      chk("c_ext_neg", {32'h0, dp_if.C_sign_ext}, 64'hFFFC0000);
      dp_if.MDRout = 1; dp_if.Cout = 1;
      #1;
      chk("bus_prio_mdr", {32'h0, dp_if.bus_mux_out}, 64'h00040000);
      dp_if.MDRout = 0;
      #1;
      chk("bus_cout", {32'h0, dp_if.bus_mux_out}, 64'hFFFC0000);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
